// File: rtl/i2c_bus_arbiter_if.sv
// Bundle between the requesters, the round-robin arbiter and the shared I2C_Master port.
// master: requester/master-model side; slave: the arbiter itself.
interface i2c_bus_arbiter_if #(
  parameter int N_REQ = 4
);
  logic [N_REQ-1:0]   req;
  logic [7*N_REQ-1:0] req_addr;
  logic [8*N_REQ-1:0] req_data;
  logic [N_REQ-1:0]   req_rw;
  logic [N_REQ-1:0]   gnt;
  logic [N_REQ-1:0]   done;
  logic               err;
  logic               busy;
  logic               m_enable;
  logic [6:0]         m_addr;
  logic [7:0]         m_data;
  logic               m_rw;
  logic               m_ready;

  modport master (
    output req, req_addr, req_data, req_rw, m_ready,
    input  gnt, done, err, busy, m_enable, m_addr, m_data, m_rw
  );

  modport slave (
    input  req, req_addr, req_data, req_rw, m_ready,
    output gnt, done, err, busy, m_enable, m_addr, m_data, m_rw
  );
endinterface

// File: rtl/i2c_bus_arbiter.sv
// Round-robin arbiter sharing one I2C_Master among N_REQ single-byte requesters.
// Optional transaction timeout: define I2C_ARB_TIMEOUT_EN.
module i2c_bus_arbiter #(
  parameter int N_REQ          = 4,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int TO_W           = 16
) (
  input  logic               clk,
  input  logic               rst,
  i2c_bus_arbiter_if.slave   bus
);
  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  // A misconfigured instance refuses to grant rather than misbehave silently.
  localparam bit CFG_OK = (N_REQ >= 2) && (N_REQ <= 8) && (TIMEOUT_CYCLES >= 1) &&
                          (TO_W >= 1) && (TO_W < 63) &&
                          (64'(TIMEOUT_CYCLES) < (64'd1 << TO_W));

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_RUN    = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  state_t             state_r, state_s;
  logic [PTR_W-1:0]   ptr_r, ptr_s;
  logic [PTR_W-1:0]   win_r, win_s;
  logic [PTR_W-1:0]   pick_s;
  logic [N_REQ-1:0]   gnt_r, gnt_s;
  logic [N_REQ-1:0]   done_r, done_s;
  logic               err_r, err_s;
  logic               busy_r;
  logic               m_enable_r, m_enable_s;
  logic [6:0]         m_addr_r, m_addr_s;
  logic [7:0]         m_data_r, m_data_s;
  logic               m_rw_r, m_rw_s;
  logic [6:0]         sel_addr_s;
  logic [7:0]         sel_data_s;
  logic               sel_rw_s;
  logic               to_hit_s;

  // First requester at or after p+1, wrapping: rotate so bit j is requester (p+1+j) mod N_REQ.
  function automatic logic [PTR_W-1:0] rr_pick(input logic [N_REQ-1:0] r,
                                               input logic [PTR_W-1:0] p);
    logic [2*N_REQ-1:0] dbl;
    logic [N_REQ-1:0]   rot;
    int                 off;
    dbl = {r, r} >> (int'(p) + 1);
    rot = dbl[N_REQ-1:0];
    off = 0;
    for (int j = N_REQ - 1; j >= 0; j--) begin
      if (rot[j]) off = j;
    end
    return PTR_W'((int'(p) + 1 + off) % N_REQ);
  endfunction

  function automatic logic [N_REQ-1:0] onehot(input logic [PTR_W-1:0] i);
    return {{(N_REQ-1){1'b0}}, 1'b1} << i;
  endfunction

  assign pick_s = rr_pick(bus.req, ptr_r);

  // Field mux for the candidate winner.
  always_comb begin
    sel_addr_s = 7'h00;
    sel_data_s = 8'h00;
    sel_rw_s   = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      sel_addr_s = (pick_s == PTR_W'(i)) ? bus.req_addr[7*i +: 7] : sel_addr_s;
      sel_data_s = (pick_s == PTR_W'(i)) ? bus.req_data[8*i +: 8] : sel_data_s;
      sel_rw_s   = (pick_s == PTR_W'(i)) ? bus.req_rw[i]          : sel_rw_s;
    end
  end

`ifdef I2C_ARB_TIMEOUT_EN
  logic [TO_W-1:0] to_cnt_r;

  assign to_hit_s = (to_cnt_r == TO_W'(TIMEOUT_CYCLES - 1));

  // Timeout counter: zero outside LAUNCH/RUN, so it is clear on entry to LAUNCH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      to_cnt_r <= '0;
    end else if ((state_r == ST_LAUNCH) || (state_r == ST_RUN)) begin
      to_cnt_r <= to_cnt_r + 1'b1;
    end else begin
      to_cnt_r <= '0;
    end
  end
`else
  assign to_hit_s = 1'b0;
`endif

  // Next-state and next-output logic.
  always_comb begin
    state_s    = state_r;
    ptr_s      = ptr_r;
    win_s      = win_r;
    gnt_s      = gnt_r;
    done_s     = '0;
    err_s      = 1'b0;
    m_enable_s = m_enable_r;
    m_addr_s   = m_addr_r;
    m_data_s   = m_data_r;
    m_rw_s     = m_rw_r;
    case (state_r)
      ST_IDLE: begin
        if (CFG_OK && (|bus.req) && bus.m_ready) begin
          state_s    = ST_LAUNCH;
          win_s      = pick_s;
          gnt_s      = onehot(pick_s);
          m_enable_s = 1'b1;
          m_addr_s   = sel_addr_s;
          m_data_s   = sel_data_s;
          m_rw_s     = sel_rw_s;
        end else begin
          gnt_s      = '0;
          m_enable_s = 1'b0;
        end
      end
      ST_LAUNCH: begin
        if (to_hit_s) begin
          state_s    = ST_DONE;
          gnt_s      = '0;
          done_s     = onehot(win_r);
          err_s      = 1'b1;
          m_enable_s = 1'b0;
        end else if (!bus.m_ready) begin
          // Master has left IDLE; dropping enable makes it STOP after this byte.
          state_s    = ST_RUN;
          m_enable_s = 1'b0;
        end else begin
          m_enable_s = 1'b1;
        end
      end
      ST_RUN: begin
        if (to_hit_s) begin
          state_s = ST_DONE;
          gnt_s   = '0;
          done_s  = onehot(win_r);
          err_s   = 1'b1;
        end else if (bus.m_ready) begin
          state_s = ST_DONE;
          gnt_s   = '0;
          done_s  = onehot(win_r);
        end else begin
          state_s = ST_RUN;
        end
        m_enable_s = 1'b0;
      end
      ST_DONE: begin
        state_s    = ST_IDLE;
        ptr_s      = win_r;
        gnt_s      = '0;
        m_enable_s = 1'b0;
      end
      default: begin
        state_s    = ST_IDLE;
        gnt_s      = '0;
        m_enable_s = 1'b0;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      ptr_r      <= PTR_W'(N_REQ - 1);
      win_r      <= '0;
      gnt_r      <= '0;
      done_r     <= '0;
      err_r      <= 1'b0;
      busy_r     <= 1'b0;
      m_enable_r <= 1'b0;
      m_addr_r   <= 7'h00;
      m_data_r   <= 8'h00;
      m_rw_r     <= 1'b0;
    end else begin
      state_r    <= state_s;
      ptr_r      <= ptr_s;
      win_r      <= win_s;
      gnt_r      <= gnt_s;
      done_r     <= done_s;
      err_r      <= err_s;
      busy_r     <= (state_s != ST_IDLE);
      m_enable_r <= m_enable_s;
      m_addr_r   <= m_addr_s;
      m_data_r   <= m_data_s;
      m_rw_r     <= m_rw_s;
    end
  end

  assign bus.gnt      = gnt_r;
  assign bus.done     = done_r;
  assign bus.err      = err_r;
  assign bus.busy     = busy_r;
  assign bus.m_enable = m_enable_r;
  assign bus.m_addr   = m_addr_r;
  assign bus.m_data   = m_data_r;
  assign bus.m_rw     = m_rw_r;
endmodule

// File: tb/tb_i2c_bus_arbiter.sv
// Randomized scoreboard bench for i2c_bus_arbiter with a behavioural I2C_Master model.
module tb_i2c_bus_arbiter;
  localparam int N  = 4;
  localparam int TO = 64;

  logic clk;
  logic rst;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  i2c_bus_arbiter_if #(.N_REQ(N)) bus ();

  i2c_bus_arbiter #(.N_REQ(N), .TIMEOUT_CYCLES(TO), .TO_W(16)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    int         idx;
    logic [6:0] addr;
    logic [7:0] data;
    logic       rw;
    logic       err;
  } txn_t;

  txn_t       exp_q[$];
  int         errors = 0;
  int         checks = 0;
  int         mptr;
  logic [6:0] a_tab[N];
  logic [7:0] d_tab[N];
  logic       rw_tab[N];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, want);
    end
  endtask

  // ---------------- I2C_Master behavioural model ----------------
  int         mstate = 0;
  int         mcnt   = 0;
  bit         stuck  = 1'b0;
  bit         hold_busy = 1'b0;
  logic [6:0] cap_addr;
  logic [7:0] cap_data;
  logic       cap_rw;

  always @(negedge clk) begin
    if (rst) begin
      mstate = 0;
      bus.m_ready = !hold_busy;
    end else begin
      case (mstate)
        0: begin
          bus.m_ready = !hold_busy;
          if (bus.m_enable) begin
            mcnt = $urandom_range(0, 2);
            mstate = 1;
          end
        end
        1: begin
          if (mcnt == 0) begin
            bus.m_ready = 1'b0;
            cap_addr = bus.m_addr;
            cap_data = bus.m_data;
            cap_rw   = bus.m_rw;
            mcnt = $urandom_range(1, 6);
            mstate = 2;
          end else begin
            mcnt--;
          end
        end
        2: begin
          if (!stuck) begin
            if (mcnt == 0) begin
              bus.m_ready = 1'b1;
              mstate = 0;
            end else begin
              mcnt--;
            end
          end
        end
        default: mstate = 0;
      endcase
    end
  end

  // ---------------- Monitor / scoreboard ----------------
  bit         prev_run = 1'b0;
  logic [N-1:0] prev_gnt = '0;
  int         cyc = 0;
  int         gnt_cycle = 0;
  txn_t       t;
  bit         exp_done;

  always @(posedge clk) begin
    #1;
    cyc++;
    if (rst) begin
      prev_run = 1'b0;
      prev_gnt = '0;
    end else begin
      check("gnt_onehot0", 32'($onehot0(bus.gnt)), 32'd1);
      if (bus.gnt != '0 && prev_gnt == '0) begin
        gnt_cycle = cyc;
        if (exp_q.size() == 0) begin
          check("unexpected_gnt", 32'(bus.gnt), 32'd0);
        end else begin
          check("gnt_winner", 32'(bus.gnt), 32'(1 << exp_q[0].idx));
          check("gnt_m_addr", 32'(bus.m_addr), 32'(exp_q[0].addr));
          check("gnt_m_data", 32'(bus.m_data), 32'(exp_q[0].data));
          check("gnt_m_rw", 32'(bus.m_rw), 32'(exp_q[0].rw));
          check("gnt_m_enable", 32'(bus.m_enable), 32'd1);
        end
      end
      // done follows m_ready's return in RUN by exactly one cycle (timeout aside)
      exp_done = prev_run && bus.m_ready;
      if (bus.done != '0) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", 32'(bus.done), 32'd0);
        end else begin
          t = exp_q.pop_front();
          check("done_who", 32'(bus.done), 32'(1 << t.idx));
          check("done_err", 32'(bus.err), 32'(t.err));
          check("done_gnt_clear", 32'(bus.gnt), 32'd0);
          check("txn_addr", 32'(cap_addr), 32'(t.addr));
          check("txn_data", 32'(cap_data), 32'(t.data));
          check("txn_rw", 32'(cap_rw), 32'(t.rw));
          if (t.err) check("timeout_cycles", 32'(cyc - gnt_cycle), 32'(TO));
          else       check("done_latency", 32'(exp_done), 32'd1);
        end
      end else if (exp_done) begin
        check("missing_done", 32'd0, 32'd1);
      end
      if (bus.err && bus.done == '0) check("err_without_done", 32'd1, 32'd0);
      prev_run = (bus.gnt != '0) && !bus.m_enable;
      prev_gnt = bus.gnt;
    end
  end

  // ---------------- Stimulus ----------------
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic rand_tables();
    for (int i = 0; i < N; i++) begin
      a_tab[i]  = 7'($urandom);
      d_tab[i]  = 8'($urandom);
      rw_tab[i] = 1'($urandom);
    end
  endtask

  // Reference: a batch asserted together is served once each, in round-robin order from mptr+1.
  task automatic issue(input logic [N-1:0] s, input logic e);
    int last;
    last = mptr;
    for (int k = 1; k <= N; k++) begin
      int i;
      i = (mptr + k) % N;
      if (s[i]) begin
        exp_q.push_back('{idx: i, addr: a_tab[i], data: d_tab[i], rw: rw_tab[i], err: e});
        last = i;
      end
    end
    mptr = last;
    for (int i = 0; i < N; i++) begin
      bus.req_addr[7*i +: 7] = a_tab[i];
      bus.req_data[8*i +: 8] = d_tab[i];
      bus.req_rw[i]          = rw_tab[i];
    end
    bus.req = s;
  endtask

  task automatic wait_batch();
    int budget;
    budget = 3000;
    while ((bus.req != '0 || exp_q.size() != 0 || bus.busy) && budget > 0) begin
      step();
      budget--;
      for (int i = 0; i < N; i++) begin
        if (bus.done[i]) bus.req[i] = 1'b0;
        if (bus.gnt[i]) begin
          // Granted fields must already be latched; disturb them and sometimes drop req.
          bus.req_addr[7*i +: 7] = 7'($urandom);
          bus.req_data[8*i +: 8] = 8'($urandom);
          bus.req_rw[i]          = 1'($urandom);
          if (!bus.m_enable && $urandom_range(0, 3) == 0) bus.req[i] = 1'b0;
        end
      end
    end
    if (budget == 0) begin
      check("batch_timeout", 32'd0, 32'd1);
      exp_q.delete();
      bus.req = '0;
    end
  endtask

  initial begin
    int budget;
    rst = 1'b1;
    bus.req = '0;
    bus.req_addr = '0;
    bus.req_data = '0;
    bus.req_rw = '0;
    mptr = N - 1;
    repeat (3) step();
    check("rst_gnt", 32'(bus.gnt), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_err", 32'(bus.err), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_m_enable", 32'(bus.m_enable), 32'd0);
    check("rst_m_addr", 32'(bus.m_addr), 32'd0);
    check("rst_m_data", 32'(bus.m_data), 32'd0);
    check("rst_m_rw", 32'(bus.m_rw), 32'd0);
    rst = 1'b0;

    // Master busy: requests must wait; then first grant latency and test 1 fields.
    hold_busy = 1'b1;
    step();
    rand_tables();
    a_tab[0] = 7'h50;
    d_tab[0] = 8'hA5;
    rw_tab[0] = 1'b0;
    issue(4'b0001, 1'b0);
    repeat (4) begin
      step();
      check("no_gnt_master_busy", 32'(bus.gnt), 32'd0);
    end
    hold_busy = 1'b0;
    step();
    check("idle_before_gnt", 32'({bus.m_ready, bus.busy}), 32'b10);
    @(posedge clk);
    #1;
    check("gnt_latency", 32'({bus.gnt, bus.m_enable, bus.busy}), 32'({4'b0001, 1'b1, 1'b1}));
    wait_batch();

    // Two simultaneous, then all four, then random batches.
    rand_tables();
    issue(4'b0101, 1'b0);
    wait_batch();
    repeat (2) begin
      rand_tables();
      issue(4'b1111, 1'b0);
      wait_batch();
    end
    repeat (30) begin
      rand_tables();
      issue(4'($urandom_range(1, 15)), 1'b0);
      wait_batch();
    end

    // Reset while a transaction is in RUN: abandoned, no done.
    rand_tables();
    issue(4'b0110, 1'b0);
    budget = 200;
    while (!(bus.gnt != '0 && !bus.m_enable && !bus.m_ready) && budget > 0) begin
      step();
      budget--;
    end
    check("reach_run", 32'(budget > 0), 32'd1);
    rst = 1'b1;
    #1;
    check("rst_run_outputs", 32'({bus.gnt, bus.m_enable, bus.busy, bus.done}),
          32'({4'b0000, 1'b0, 1'b0, 4'b0000}));
    exp_q.delete();
    bus.req = '0;
    mptr = N - 1;
    step();
    step();
    rst = 1'b0;
    repeat (3) step();
    check("post_rst_quiet", 32'({bus.gnt, bus.busy}), 32'd0);
    rand_tables();
    issue(4'b0001, 1'b0);
    wait_batch();

`ifdef I2C_ARB_TIMEOUT_EN
    // Master stuck after launch: done+err after TO cycles, then back to IDLE.
    stuck = 1'b1;
    rand_tables();
    issue(4'b1000, 1'b1);
    wait_batch();
    step();
    check("timeout_idle", 32'({bus.busy, bus.gnt}), 32'd0);
    stuck = 1'b0;
    repeat (10) step();
`endif

    repeat (5) step();
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
